// File: rtl/mixer_frame_sequencer.sv
// -----------------------------------------------------------------------------
// mixer_frame_sequencer
//
// Once per audio frame, mixes two buffered stereo sources into one registered
// stereo sample for the I2S transmit side. Channel A is the local capture and
// channel B is the remote/jitter-buffer output. Each channel has a one-deep
// holding register with a full flag. A single adder is time-shared between
// the left sum and the right sum. A source that is missing at frame time is
// replaced by silence, and the miss is counted.
//
// Build option:
//   MIXER_SATURATE_EN  defined   : the mixed sum clamps to the signed range.
//                      undefined : the mixed sum wraps (low 'size' bits kept).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   frame_tick          one-cycle strobe at the sample rate
//   a_valid/a_ready     channel A offer/accept, a_left/a_right samples
//   b_valid/b_ready     channel B offer/accept, b_left/b_right samples
//   mute_a, mute_b      the channel contributes zero
//   cnt_clr             clears underrun counters and tick_miss
//   out_valid           one-cycle strobe: out_left/out_right updated
//   out_left/out_right  mixed stereo result, held until the next frame
//   underrun_a/_b       saturating count of frames mixed with source absent
//   tick_miss           sticky: frame_tick arrived while a frame was in flight
// -----------------------------------------------------------------------------
module mixer_frame_sequencer #(
    parameter int size  = 24,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [size-1:0]  a_left,
    input  logic [size-1:0]  a_right,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [size-1:0]  b_left,
    input  logic [size-1:0]  b_right,
    input  logic             mute_a,
    input  logic             mute_b,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic [size-1:0]  out_left,
    output logic [size-1:0]  out_right,
    output logic [CNT_W-1:0] underrun_a,
    output logic [CNT_W-1:0] underrun_b,
    output logic             tick_miss
);

    typedef enum logic [1:0] {IDLE, MIX_L, MIX_R, OUT} state_t;

    state_t            state_q;

    // Holding registers and full flags
    logic [size-1:0]   a_left_q, a_right_q, b_left_q, b_right_q;
    logic              a_full_q, b_full_q;

    // Frame snapshot taken on the tick edge
    logic              a_use_q, b_use_q;     // channel contributes to the sum
    logic              a_taken_q, b_taken_q; // channel was full: consume it
    logic              a_und_q, b_und_q;     // channel absent and not muted

    logic [size-1:0]   sum_q;                // left result while right is computed
    logic              out_valid_q;
    logic [size-1:0]   out_left_q, out_right_q;
    logic [CNT_W-1:0]  und_cnt_a_q, und_cnt_b_q;
    logic              tick_miss_q;

    // Shared adder: operand select and result reduction
    logic [size-1:0]   op_a_d, op_b_d;
    logic [size-1:0]   sum_d;

    // Ready is combinational so it is valid in the very first cycle after
    // reset release while still reading 0 during reset.
    assign a_ready = !rst && !a_full_q && (state_q == IDLE);
    assign b_ready = !rst && !b_full_q && (state_q == IDLE);

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        op_a_d = '0;
        op_b_d = '0;
        if (a_use_q) op_a_d = (state_q == MIX_R) ? a_right_q : a_left_q;
        if (b_use_q) op_b_d = (state_q == MIX_R) ? b_right_q : b_left_q;
    end

`ifdef MIXER_SATURATE_EN
    logic [size:0] sum_wide_d;

    always_comb begin
        sum_wide_d = {op_a_d[size-1], op_a_d} + {op_b_d[size-1], op_b_d};
        // The sign bit and the bit below it differ only on overflow; the
        // extension bit then carries the true sign of the result.
        if (sum_wide_d[size] != sum_wide_d[size-1])
            sum_d = sum_wide_d[size] ? {1'b1, {(size-1){1'b0}}}
                                     : {1'b0, {(size-1){1'b1}}};
        else
            sum_d = sum_wide_d[size-1:0];
    end
`else
    // The low 'size' bits of the sign-extended sum equal a plain size-bit
    // add, so the extension bit is not built at all in wrap mode.
    always_comb begin
        sum_d = op_a_d + op_b_d;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the holding registers are reset too: a frame abandoned by
            // reset must not leak stale samples into a later frame.
            state_q     <= IDLE;
            a_left_q    <= '0;
            a_right_q   <= '0;
            b_left_q    <= '0;
            b_right_q   <= '0;
            a_full_q    <= 1'b0;
            b_full_q    <= 1'b0;
            a_use_q     <= 1'b0;
            b_use_q     <= 1'b0;
            a_taken_q   <= 1'b0;
            b_taken_q   <= 1'b0;
            a_und_q     <= 1'b0;
            b_und_q     <= 1'b0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_left_q  <= '0;
            out_right_q <= '0;
            und_cnt_a_q <= '0;
            und_cnt_b_q <= '0;
            tick_miss_q <= 1'b0;
        end else begin
            // Capture: ready is only high in IDLE, so this never collides
            // with the full-flag clear in OUT.
            if (a_valid && a_ready) begin
                a_left_q  <= a_left;
                a_right_q <= a_right;
                a_full_q  <= 1'b1;
            end
            if (b_valid && b_ready) begin
                b_left_q  <= b_left;
                b_right_q <= b_right;
                b_full_q  <= 1'b1;
            end

            out_valid_q <= 1'b0;

            if (cnt_clr)
                tick_miss_q <= 1'b0;
            else if (frame_tick && state_q != IDLE)
                tick_miss_q <= 1'b1;

            // Clear wins over a coincident increment in OUT below.
            if (cnt_clr) begin
                und_cnt_a_q <= '0;
                und_cnt_b_q <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (frame_tick) begin
                        // Snapshot uses pre-edge full flags: a sample captured
                        // on this same edge waits for the next frame.
                        a_use_q   <= a_full_q && !mute_a;
                        b_use_q   <= b_full_q && !mute_b;
                        a_taken_q <= a_full_q;
                        b_taken_q <= b_full_q;
                        a_und_q   <= !a_full_q && !mute_a;
                        b_und_q   <= !b_full_q && !mute_b;
                        state_q   <= MIX_L;
                    end
                end
                MIX_L: begin
                    sum_q   <= sum_d;
                    state_q <= MIX_R;
                end
                MIX_R: begin
                    // Both halves land together so the outputs only change
                    // in the cycle out_valid is high.
                    out_left_q  <= sum_q;
                    out_right_q <= sum_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (a_taken_q) a_full_q <= 1'b0;
                    if (b_taken_q) b_full_q <= 1'b0;
                    if (!cnt_clr && a_und_q && (und_cnt_a_q != '1))
                        und_cnt_a_q <= und_cnt_a_q + 1'b1;
                    if (!cnt_clr && b_und_q && (und_cnt_b_q != '1))
                        und_cnt_b_q <= und_cnt_b_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_left   = out_left_q;
    assign out_right  = out_right_q;
    assign underrun_a = und_cnt_a_q;
    assign underrun_b = und_cnt_b_q;
    assign tick_miss  = tick_miss_q;

endmodule
